// File: rtl/aes_pkg.sv
// Shared AES key-schedule definitions.
//   word_t        : 32-bit schedule word
//   KEYLEN_*      : key_len encodings (11 is illegal)
//   state_t       : expander FSM states
//   nk_of/nr_of   : key length in words / round count for a key_len code
//   xtime         : multiply-by-x in GF(2^8), used to step Rcon
package aes_pkg;

  typedef logic [31:0] word_t;

  localparam logic [1:0] KEYLEN_128 = 2'b00;
  localparam logic [1:0] KEYLEN_192 = 2'b01;
  localparam logic [1:0] KEYLEN_256 = 2'b10;
  localparam logic [1:0] KEYLEN_BAD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_EXPAND
  } state_t;

  function automatic logic [3:0] nk_of(input logic [1:0] kl);
    logic [3:0] n;
    case (kl)
      KEYLEN_128: n = 4'd4;
      KEYLEN_192: n = 4'd6;
      default:    n = 4'd8;
    endcase
    return n;
  endfunction

  function automatic logic [3:0] nr_of(input logic [1:0] kl);
    logic [3:0] n;
    case (kl)
      KEYLEN_128: n = 4'd10;
      KEYLEN_192: n = 4'd12;
      default:    n = 4'd14;
    endcase
    return n;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_subword.sv
// AES SubWord: four independent S-box lookups on a 32-bit word.
//   din  : input word
//   dout : each byte of din replaced by its S-box image
module aes_subword (
  input  logic [31:0] din,
  output logic [31:0] dout
);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign dout[31:24] = SBOX[din[31:24]];
  assign dout[23:16] = SBOX[din[23:16]];
  assign dout[15:8]  = SBOX[din[15:8]];
  assign dout[7:0]   = SBOX[din[7:0]];

endmodule

// File: rtl/key_schedule_seq.sv
// Sequential AES-128/192/256 key expansion, one 32-bit word per clock,
// into a WORDS-deep round-key store with a registered 4-word read port.
//   clk, reset : clock, asynchronous active-high reset
//   start      : expansion request, sampled only in IDLE
//   key_len    : 00=AES-128, 01=AES-192, 10=AES-256, 11 illegal (sets err)
//   key_in     : cipher key, word 0 in the most significant 32 bits
//   busy       : expansion in progress
//   done       : one-cycle pulse at the end of expansion
//   rk_avail   : number of complete round keys currently in the store
//   rd_round   : round key to read
//   rd_key     : registered round key (word 4r in the MSBs), zero past Nr
//   err        : sticky illegal-key_len flag, cleared by a legal start
module key_schedule_seq
  import aes_pkg::*;
#(
  parameter int unsigned NK_MAX = 8,
  parameter int unsigned WORDS  = 4 * (NK_MAX + 7)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [1:0]            key_len,
  input  logic [32*NK_MAX-1:0]  key_in,
  output logic                  busy,
  output logic                  done,
  output logic [3:0]            rk_avail,
  input  logic [3:0]            rd_round,
  output logic [127:0]          rd_key,
  output logic                  err
);

  localparam int unsigned IW = $clog2(WORDS + 1);
  localparam int unsigned CW = $clog2(NK_MAX);

  state_t               state_q, state_d;
  logic [1:0]           kl_q;
  logic [32*NK_MAX-1:0] key_q;
  logic [IW-1:0]        i_q;
  logic [CW-1:0]        ctr_q;     // i mod Nk
  logic [7:0]           rcon_q;
  word_t                w [WORDS];

  logic [3:0]    nk, nr;
  logic [IW-1:0] last_i, rd_base;
  logic          accept, expand_we, rot_sel, sub_sel;
  word_t         prev_w, back_w, sub_in, sub_out, temp, new_w;

  assign nk     = nk_of(kl_q);
  assign nr     = nr_of(kl_q);
  assign last_i = IW'({nr + 4'd1, 2'b00});
  assign busy   = (state_q != ST_IDLE);

  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    expand_we = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && key_len != KEYLEN_BAD) begin
          accept  = 1'b1;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: state_d = ST_EXPAND;
      ST_EXPAND: begin
        // The cycle after the last word is written carries no write; it
        // retires the expansion and raises done as busy falls.
        if (i_q == last_i) state_d = ST_IDLE;
        else               expand_we = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // One S-box instance serves both the RotWord and the AES-256 mid-key
  // SubWord step; the rotation is applied ahead of it only when needed.
  assign rot_sel = (ctr_q == '0);
  assign sub_sel = (nk == 4'd8) && (ctr_q == CW'(4));
  assign prev_w  = w[i_q - IW'(1)];
  assign back_w  = w[i_q - IW'(nk)];
  assign sub_in  = rot_sel ? {prev_w[23:0], prev_w[31:24]} : prev_w;

  aes_subword u_subword (
    .din  (sub_in),
    .dout (sub_out)
  );

  always_comb begin
    temp = prev_w;
    if (rot_sel)      temp = sub_out ^ {rcon_q, 24'h0};
    else if (sub_sel) temp = sub_out;
  end

  assign new_w = back_w ^ temp;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      kl_q     <= KEYLEN_128;
      key_q    <= '0;
      i_q      <= '0;
      ctr_q    <= '0;
      rcon_q   <= 8'h01;
      rk_avail <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state_q <= state_d;
      done    <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            err      <= 1'b0;
            kl_q     <= key_len;
            key_q    <= key_in;
            rk_avail <= '0;
          end else if (start) begin
            err <= 1'b1;
          end
        end
        ST_LOAD: begin
          i_q      <= IW'(nk);
          ctr_q    <= '0;
          rcon_q   <= 8'h01;
          rk_avail <= nk >> 2;
        end
        ST_EXPAND: begin
          if (expand_we) begin
            i_q   <= i_q + IW'(1);
            ctr_q <= (ctr_q == CW'(nk - 4'd1)) ? '0 : ctr_q + CW'(1);
            if (rot_sel) rcon_q <= xtime(rcon_q);
            if (i_q[1:0] == 2'b11) rk_avail <= rk_avail + 4'd1;
          end else begin
            done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Store contents are meaningless after reset; rk_avail gates validity.
  always_ff @(posedge clk) begin
    if (state_q == ST_LOAD) begin
      for (int unsigned j = 0; j < NK_MAX; j++)
        if (j < 32'(nk)) w[IW'(j)] <= key_q[32*(NK_MAX-1-j) +: 32];
    end else if (expand_we) begin
      w[i_q] <= new_w;
    end
  end

  assign rd_base = IW'({rd_round, 2'b00});

  always_ff @(posedge clk or posedge reset) begin
    if (reset)              rd_key <= '0;
    else if (rd_round > nr) rd_key <= '0;
    else rd_key <= {w[rd_base], w[rd_base + IW'(1)],
                    w[rd_base + IW'(2)], w[rd_base + IW'(3)]};
  end

endmodule
